pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It watches the IF/ID, ID/EX and EX/MEM stage contents, detects load-use hazards, branch redirects and multi-cycle data-memory accesses, and drives hold/bubble/flush controls into the PC and the inter-stage registers. A small FSM tracks outstanding data-memory accesses with a timeout. Saturating-free (wrapping) performance counters record stall and flush cycles.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 36 +++
 rtl/pipeline_hazard_ctrl_perf_counter.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the memory-access FSM state encoding and the register-address width.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } hz_state_e;

   // A destination of x0 never creates a dependency, because x0 is hardwired to zero.
   function automatic logic load_use_hit(
      input logic                  memread,
      input logic [REG_ADDR_W-1:0] rd,
      input logic [REG_ADDR_W-1:0] rs1,
      input logic [REG_ADDR_W-1:0] rs2
   );
      return memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-content inputs and hold/bubble/flush controls of the hazard sequencer.
// The slave side is the sequencer; the master side is the pipeline datapath.
interface pipeline_hazard_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic [REG_ADDR_W-1:0] ifid_rs1_i;
   logic [REG_ADDR_W-1:0] ifid_rs2_i;
   logic                  idex_memread_i;
   logic [REG_ADDR_W-1:0] idex_rd_i;
   logic                  branch_taken_i;
   logic                  exmem_memread_i;
   logic                  exmem_memwrite_i;
   logic                  mem_ack_i;
   logic                  mem_req_o;
   logic                  pc_write_o;
   logic                  ifid_write_o;
   logic                  ifid_flush_o;
   logic                  idex_bubble_o;
   logic                  exmem_hold_o;
   logic                  memwb_bubble_o;

   modport slave (
      input  ifid_rs1_i, ifid_rs2_i, idex_memread_i, idex_rd_i, branch_taken_i,
             exmem_memread_i, exmem_memwrite_i, mem_ack_i,
      output mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
             exmem_hold_o, memwb_bubble_o
   );

   modport master (
      output ifid_rs1_i, ifid_rs2_i, idex_memread_i, idex_rd_i, branch_taken_i,
             exmem_memread_i, exmem_memwrite_i, mem_ack_i,
      input  mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
             exmem_hold_o, memwb_bubble_o
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Wrapping event counter: adds one on every enabled cycle, rolls over at 2^W.
module hazard_perf_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze > load-use stall > branch flush.
// Controls are combinational from FSM state and stage contents; counters update on the clock edge.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   pipeline_hazard_ctrl_if.slave   hz,
   output logic                    err_o,
   output logic [CNT_W-1:0]        stall_cnt_o,
   output logic [CNT_W-1:0]        flush_cnt_o
);

   localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_e         state_q;
   hz_state_e         state_d;
   logic [TMR_W-1:0]  timer_q;
   logic [TMR_W-1:0]  timer_d;

   logic mem_acc;
   logic freeze;
   logic load_use;
   logic branch_flush;
   logic mem_req;
   logic stall_evt;
   logic cnt_en_ok;

   assign mem_acc = hz.exmem_memread_i | hz.exmem_memwrite_i;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      freeze  = 1'b0;
      mem_req = 1'b0;
      unique case (state_q)
         RUN: begin
            mem_req = mem_acc;
            if (mem_acc && !hz.mem_ack_i) begin
               freeze  = 1'b1;
               state_d = MEM_WAIT;
               timer_d = TMR_W'(1);
            end
         end
         MEM_WAIT: begin
            mem_req = 1'b1;
            if (hz.mem_ack_i) begin
               state_d = RUN;
            end else begin
               freeze = 1'b1;
               if (timer_q == TMR_W'(MEM_TIMEOUT)) begin
                  state_d = ERR;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end
         ERR: begin
            freeze = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Branch operands may still be in flight behind a load, so a load-use stall masks the redirect.
   always_comb begin
      load_use     = 1'b0;
      branch_flush = 1'b0;
      if (!freeze) begin
         load_use     = load_use_hit(hz.idex_memread_i, hz.idex_rd_i,
                                     hz.ifid_rs1_i, hz.ifid_rs2_i);
         branch_flush = hz.branch_taken_i && !load_use;
      end
   end

   always_comb begin
      hz.mem_req_o      = mem_req;
      hz.pc_write_o     = !(freeze || load_use);
      hz.ifid_write_o   = !(freeze || load_use);
      hz.ifid_flush_o   = branch_flush;
      hz.idex_bubble_o  = load_use;
      hz.exmem_hold_o   = freeze;
      hz.memwb_bubble_o = freeze;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= RUN;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   assign err_o     = (state_q == ERR);
   assign stall_evt = freeze || load_use;
   assign cnt_en_ok = (state_q != ERR);

   hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (stall_evt && cnt_en_ok),
      .cnt_o (stall_cnt_o)
   );

   hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (branch_flush && cnt_en_ok),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a short bus timeout.
module tb_pipeline_hazard_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        err_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;

   int n_run;
   int n_fail;

   pipeline_hazard_ctrl_if hz ();

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_W       (32)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .hz          (hz.slave),
      .err_o       (err_o),
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hz.ifid_rs1_i       = '0;
      hz.ifid_rs2_i       = '0;
      hz.idex_memread_i   = 1'b0;
      hz.idex_rd_i        = '0;
      hz.branch_taken_i   = 1'b0;
      hz.exmem_memread_i  = 1'b0;
      hz.exmem_memwrite_i = 1'b0;
      hz.mem_ack_i        = 1'b0;
   endtask

   // Advance one clock; inputs and checks happen 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_ctrl(input string tag, input logic [6:0] exp);
      chk(tag, {25'd0, hz.mem_req_o, hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o,
                hz.idex_bubble_o, hz.exmem_hold_o, hz.memwb_bubble_o}, {25'd0, exp});
   endtask

   // Control vector order: mem_req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble
   localparam logic [6:0] C_IDLE   = 7'b0110000;
   localparam logic [6:0] C_LU     = 7'b0000100;
   localparam logic [6:0] C_FRZ    = 7'b1000011;
   localparam logic [6:0] C_FRZ_E  = 7'b0000011;
   localparam logic [6:0] C_BR     = 7'b0111000;
   localparam logic [6:0] C_MEMOK  = 7'b1110000;

   initial begin
      n_run  = 0;
      n_fail = 0;
      idle();
      rst_i = 1'b0;
      #12;
      chk_ctrl("reset_ctrl", C_IDLE);
      chk("reset_err", {31'd0, err_o}, 32'd0);
      chk("reset_stall", stall_cnt_o, 32'd0);
      chk("reset_flush", flush_cnt_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();

      // Load x5 in EX, rs2 of ID is x5
      hz.idex_memread_i = 1'b1;
      hz.idex_rd_i      = 5'd5;
      hz.ifid_rs1_i     = 5'd3;
      hz.ifid_rs2_i     = 5'd5;
      #1 chk_ctrl("lu_ctrl", C_LU);
      tick();
      chk("lu_stall_cnt", stall_cnt_o, 32'd1);

      // Destination x0 never stalls
      hz.idex_rd_i  = 5'd0;
      hz.ifid_rs1_i = 5'd0;
      #1 chk_ctrl("lu_x0_ctrl", C_IDLE);
      tick();
      chk("lu_x0_stall_cnt", stall_cnt_o, 32'd1);
      idle();

      // Load in MEM, three cycles without ack, then ack
      hz.exmem_memread_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk_ctrl($sformatf("memwait_frz%0d", i), C_FRZ);
         tick();
      end
      hz.mem_ack_i = 1'b1;
      #1 chk_ctrl("memwait_ack", C_MEMOK);
      tick();
      idle();
      #1 chk_ctrl("memwait_back_run", C_IDLE);
      chk("memwait_stall_cnt", stall_cnt_o, 32'd4);

      // Branch alongside a load-use: only the stall is taken
      hz.idex_memread_i = 1'b1;
      hz.idex_rd_i      = 5'd7;
      hz.ifid_rs1_i     = 5'd7;
      hz.branch_taken_i = 1'b1;
      #1 chk_ctrl("br_lu_ctrl", C_LU);
      tick();
      chk("br_lu_flush_cnt", flush_cnt_o, 32'd0);
      chk("br_lu_stall_cnt", stall_cnt_o, 32'd5);
      idle();
      hz.branch_taken_i = 1'b1;
      #1 chk_ctrl("br_ctrl", C_BR);
      tick();
      chk("br_flush_cnt", flush_cnt_o, 32'd1);
      chk("br_stall_cnt", stall_cnt_o, 32'd5);
      idle();

      // Zero-wait store
      hz.exmem_memwrite_i = 1'b1;
      hz.mem_ack_i        = 1'b1;
      #1 chk_ctrl("zw_ctrl", C_MEMOK);
      tick();
      chk("zw_stall_cnt", stall_cnt_o, 32'd5);
      idle();

      // Store never acked: five waiting cycles, then ERR
      hz.exmem_memwrite_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 chk_ctrl($sformatf("to_frz%0d", i), C_FRZ);
         chk($sformatf("to_err_lo%0d", i), {31'd0, err_o}, 32'd0);
         tick();
      end
      chk("to_err", {31'd0, err_o}, 32'd1);
      chk_ctrl("to_err_ctrl", C_FRZ_E);
      chk("to_stall_cnt", stall_cnt_o, 32'd10);
      hz.branch_taken_i = 1'b1;
      hz.mem_ack_i      = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk_ctrl("err_sticky_ctrl", C_FRZ_E);
      chk("err_sticky", {31'd0, err_o}, 32'd1);
      chk("err_stall_frozen", stall_cnt_o, 32'd10);
      chk("err_flush_frozen", flush_cnt_o, 32'd1);

      // Asynchronous reset in the middle of a cycle
      hz.branch_taken_i = 1'b0;
      hz.mem_ack_i      = 1'b0;
      #2 rst_i = 1'b0;
      #1;
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk_ctrl("rst_ctrl_run", C_FRZ);
      chk("rst_stall", stall_cnt_o, 32'd0);
      chk("rst_flush", flush_cnt_o, 32'd0);
      idle();
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();
      chk_ctrl("post_rst_idle", C_IDLE);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
